ctr_pr_dec: RTL

Sequential decoder for the `ctr_pr<N>` pseudo-random counter family. It converts a counter state back into its binary step index: the number of `inc` steps taken from power-up. It replays the same next-state sequence from 0 until it matches the presented value. It sits on the read side of any logic that timestamps or addresses with `ctr_pr<N>` values and needs ordinal or binary arithmetic on them.

---
 rtl/ctr_pr_dec_pkg.sv | 28 ++
 rtl/ctr_pr_dec_step.sv | 23 ++
 rtl/ctr_pr_dec.sv | 90 +++++++++
 3 files changed

// File: rtl/ctr_pr_dec_pkg.sv
// Shared definitions for the ctr_pr<N> counter family and its decoder.
// Tap masks select the feedback bits of a left-shifting LFSR; bit W-1 is always tapped.
package ctr_pr_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] CTR_PR_TAPS_4 = 8'h0C;
   localparam logic [7:0] CTR_PR_TAPS_5 = 8'h14;
   localparam logic [7:0] CTR_PR_TAPS_6 = 8'h30;
   localparam logic [7:0] CTR_PR_TAPS_7 = 8'h60;
   localparam logic [7:0] CTR_PR_TAPS_8 = 8'hB8;
   localparam logic [7:0] CTR_PR_START  = 8'h00;

   function automatic logic [7:0] ctr_pr_taps(input int w);
      case (w)
         4:       return CTR_PR_TAPS_4;
         5:       return CTR_PR_TAPS_5;
         6:       return CTR_PR_TAPS_6;
         7:       return CTR_PR_TAPS_7;
         default: return CTR_PR_TAPS_8;
      endcase
   endfunction

endpackage

// File: rtl/ctr_pr_dec_step.sv
// Combinational next-state function of ctr_pr<W>, shared with the counters themselves.
// The all-zero-low-bits patch splices state 0 into the LFSR cycle, giving period 2^W.
module ctr_pr_step
   import ctr_pr_dec_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] cur,
   output logic [W-1:0] nxt
);

   localparam logic [7:0]   TAPS_FULL = ctr_pr_taps(W);
   localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

   logic fb;

   always_comb begin
      fb = ^(cur & TAPS);
      if (cur[W-2:0] == '0) fb = ~fb;
      nxt = {cur[W-2:0], fb};
   end

endmodule

// File: rtl/ctr_pr_dec.sv
// Decodes a ctr_pr<W> value back to its step index by replaying the sequence from 0.
//
// state  | meaning
// IDLE   | ready for a new value
// SEARCH | walking the sequence, one step per cycle, until walker matches target
// DONE   | result held on out until the consumer takes it
module ctr_pr_dec
   import ctr_pr_dec_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out,
   output logic         out_valid,
   input  logic         out_ready
);

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] target;
   logic [W-1:0] walker;
   logic [W-1:0] walker_nxt;
   logic [W-1:0] idx;
   logic         hit;

   ctr_pr_step #(.W(W)) u_step (
      .cur (walker),
      .nxt (walker_nxt)
   );

   // Full period guarantees a match by the last index; the bound only caps the walk.
   assign hit = (walker == target) || (idx == {W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (in_valid)  state_nxt = ST_SEARCH;
         ST_SEARCH: if (hit)       state_nxt = ST_DONE;
         ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target    <= '0;
         walker    <= '0;
         idx       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  target <= in;
                  walker <= CTR_PR_START[W-1:0];
                  idx    <= '0;
               end
            end
            ST_SEARCH: begin
               if (hit) begin
                  out       <= idx;
                  out_valid <= 1'b1;
               end else begin
                  walker <= walker_nxt;
                  idx    <= idx + W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
